// File: rtl/parameter_controller_pkg.sv
// Shared types and constants for the synth control path.
//   - parameter_t: the 67-bit synth-wide control register and its field types.
//   - DEFAULT_PARAMETERS: power-on / Reset-All-Controllers values.
//   - MIDI status constants and the byte-parser state enum.
//   - Small mapping helpers that turn a 7-bit CC value into a field value.
package parameter_controller_pkg;

  // ---------------- parameter bundle ----------------
  typedef logic [6:0] percent_t;   // 0..100
  typedef logic [6:0] time_t;

  typedef enum logic [1:0] {SINE = 2'd0, SQUARE = 2'd1, TRIANGLE = 2'd2} wave_t;
  typedef enum logic {POLYPHONY = 1'b0, ARPEGGIATOR = 1'b1} dispatcher_mode_t;
  typedef enum logic [2:0] {
    ARP_MODE_UP = 3'd0, ARP_MODE_DOWN = 3'd1, ARP_MODE_UP_DOWN = 3'd2,
    ARP_MODE_DOWN_UP = 3'd3, ARP_MODE_RANDOM = 3'd4, ARP_MODE_CHORD = 3'd5
  } arp_mode_t;
  typedef enum logic [2:0] {
    ARP_RATE_WHOLE = 3'd0, ARP_RATE_HALF = 3'd1, ARP_RATE_QUARTER = 3'd2,
    ARP_RATE_EIGHTH = 3'd3, ARP_RATE_SIXTEENTH = 3'd4, ARP_RATE_THIRTY_SECOND = 3'd5,
    ARP_RATE_QUARTER_TRIPLET = 3'd6, ARP_RATE_EIGHTH_TRIPLET = 3'd7
  } arp_rate_t;
  typedef enum logic [1:0] {
    ARP_RHYTHM_O = 2'd0, ARP_RHYTHM_OX = 2'd1, ARP_RHYTHM_OXX = 2'd2, ARP_RHYTHM_OOX = 2'd3
  } arp_rhythm_t;

  typedef struct packed {
    percent_t         volume;
    logic [6:0]       unison_detune;
    time_t            attack_time;
    time_t            decay_time;
    percent_t         sustain_level;
    time_t            release_time;
    logic [6:0]       tempo;
    wave_t            wave;
    percent_t         duty_cycle;
    dispatcher_mode_t dispatcher_mode;
    arp_mode_t        arp_mode;
    arp_rate_t        arp_rate;
    arp_rhythm_t      arp_rhythm;
  } parameter_t;

  localparam int PARAM_W = $bits(parameter_t);

  localparam parameter_t DEFAULT_PARAMETERS = '{
    volume:          7'd100,
    unison_detune:   7'd0,
    attack_time:     7'd0,
    decay_time:      7'd0,
    sustain_level:   7'd100,
    release_time:    7'd0,
    tempo:           7'd64,
    wave:            SINE,
    duty_cycle:      7'd50,
    dispatcher_mode: POLYPHONY,
    arp_mode:        ARP_MODE_UP,
    arp_rate:        ARP_RATE_EIGHTH,
    arp_rhythm:      ARP_RHYTHM_O
  };

  localparam logic [6:0] CC_RESET_ALL = 7'd121;

  // ---------------- MIDI ----------------
  localparam logic [3:0] NOTE_OFF         = 4'h8;
  localparam logic [3:0] NOTE_ON          = 4'h9;
  localparam logic [3:0] CONTROL_CHANGE   = 4'hB;
  localparam logic [3:0] PROGRAM_CHANGE   = 4'hC;
  localparam logic [3:0] CHANNEL_PRESSURE = 4'hD;

  localparam logic [7:0] SYSEX_START  = 8'hF0;
  localparam logic [7:0] SYSEX_END    = 8'hF7;
  localparam logic [7:0] REALTIME_MIN = 8'hF8;

  typedef enum logic [1:0] {IDLE = 2'd0, DATA1 = 2'd1, DATA2 = 2'd2, SYSEX = 2'd3} parser_state_t;

  // ---------------- CC value mapping ----------------
  function automatic percent_t sat_percent(input logic [6:0] d);
    return (d > 7'd100) ? 7'd100 : d;
  endfunction

  // Top two bits of the CC value; code 3 has no waveform and clamps to TRIANGLE.
  function automatic wave_t map_wave(input logic [1:0] sel);
    case (sel)
      2'd0:    return SINE;
      2'd1:    return SQUARE;
      default: return TRIANGLE;
    endcase
  endfunction

  // Top three bits of the CC value; codes 6 and 7 clamp to CHORD.
  function automatic arp_mode_t map_arp_mode(input logic [2:0] sel);
    return (sel >= 3'd6) ? ARP_MODE_CHORD : arp_mode_t'(sel);
  endfunction

endpackage

// File: rtl/midi_byte_parser.sv
// MIDI byte-stream parser with running status.
// Ports:
//   clock, reset          : single clock, synchronous active-high reset
//   midi_byte, midi_valid : one received byte per valid cycle, no backpressure
//   msg_valid             : combinational pulse in the cycle the completing data
//                           byte is presented, so the consumer can register the
//                           result on that same edge
//   msg_status/data1/data2: the completed message (data2 = 0 for 1-data-byte msgs)
module midi_byte_parser
  import parameter_controller_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] midi_byte,
  input  logic       midi_valid,
  output logic       msg_valid,
  output logic [7:0] msg_status,
  output logic [6:0] msg_data1,
  output logic [6:0] msg_data2
);

  parser_state_t state_reg, state_next;
  // Running status; 8'h00 means "none" since any valid status has bit 7 set.
  logic [7:0] running_reg, running_next;
  logic [6:0] data1_reg, data1_next;

  logic running_ok;
  logic one_data_byte;
  logic is_data;

  assign running_ok    = running_reg[7];
  assign one_data_byte = (running_reg[7:4] == PROGRAM_CHANGE) ||
                         (running_reg[7:4] == CHANNEL_PRESSURE);
  assign is_data       = midi_valid && !midi_byte[7];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= IDLE;
      running_reg <= 8'h00;
      data1_reg   <= 7'd0;
    end else begin
      state_reg   <= state_next;
      running_reg <= running_next;
      data1_reg   <= data1_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    running_next = running_reg;
    data1_next   = data1_reg;
    if (midi_valid && midi_byte[7]) begin
      // Status bytes are handled identically in every state, including SYSEX.
      if (midi_byte >= REALTIME_MIN) begin
        // real-time: transparent
      end else if (midi_byte < SYSEX_START) begin
        running_next = midi_byte;
        state_next   = DATA1;
      end else if (midi_byte == SYSEX_START) begin
        running_next = 8'h00;
        state_next   = SYSEX;
      end else begin
        // F1..F7 (SYSEX_END included): system common, drops running status
        running_next = 8'h00;
        state_next   = IDLE;
      end
    end else if (is_data) begin
      case (state_reg)
        IDLE, DATA1: begin
          if (running_ok) begin
            data1_next = midi_byte[6:0];
            state_next = one_data_byte ? IDLE : DATA2;
          end
        end
        DATA2:   state_next = IDLE;
        default: state_next = state_reg;  // SYSEX payload discarded
      endcase
    end
  end

  always_comb begin
    msg_valid  = 1'b0;
    msg_status = running_reg;
    msg_data1  = data1_reg;
    msg_data2  = midi_byte[6:0];
    if (is_data) begin
      case (state_reg)
        IDLE, DATA1: begin
          if (running_ok && one_data_byte) begin
            msg_valid = 1'b1;
            msg_data1 = midi_byte[6:0];
            msg_data2 = 7'd0;
          end
        end
        DATA2:   msg_valid = 1'b1;
        default: msg_valid = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/parameter_controller.sv
// Synth parameter register driven by MIDI Control Change messages.
// Ports:
//   clock, reset          : single clock, synchronous active-high reset
//   midi_byte, midi_valid : raw MIDI byte stream from the UART receiver
//   parameters            : registered parameter_t bundle (67 bits)
//   param_updated         : one-cycle pulse when a field was written or the
//                           bundle was returned to defaults by CC 121
module parameter_controller
  import parameter_controller_pkg::*;
#(
  parameter logic [3:0] CHANNEL       = 4'd0,
  parameter logic [6:0] CC_VOLUME     = 7'd7,
  parameter logic [6:0] CC_DETUNE     = 7'd94,
  parameter logic [6:0] CC_ATTACK     = 7'd73,
  parameter logic [6:0] CC_DECAY      = 7'd75,
  parameter logic [6:0] CC_SUSTAIN    = 7'd79,
  parameter logic [6:0] CC_RELEASE    = 7'd72,
  parameter logic [6:0] CC_TEMPO      = 7'd14,
  parameter logic [6:0] CC_WAVE       = 7'd15,
  parameter logic [6:0] CC_DUTY       = 7'd16,
  parameter logic [6:0] CC_DISPATCH   = 7'd17,
  parameter logic [6:0] CC_ARP_MODE   = 7'd18,
  parameter logic [6:0] CC_ARP_RATE   = 7'd19,
  parameter logic [6:0] CC_ARP_RHYTHM = 7'd20
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [7:0]         midi_byte,
  input  logic               midi_valid,
  output logic [PARAM_W-1:0] parameters,
  output logic               param_updated
);

  logic       msg_valid;
  logic [7:0] msg_status;
  logic [6:0] msg_data1;
  logic [6:0] msg_data2;

  midi_byte_parser u_parser (
    .clock      (clock),
    .reset      (reset),
    .midi_byte  (midi_byte),
    .midi_valid (midi_valid),
    .msg_valid  (msg_valid),
    .msg_status (msg_status),
    .msg_data1  (msg_data1),
    .msg_data2  (msg_data2)
  );

  parameter_t params_reg, params_next;
  logic       updated_reg, updated_next;
  logic       cc_hit;

  assign cc_hit = msg_valid && (msg_status == {CONTROL_CHANGE, CHANNEL});

  // Priority chain in declaration order so duplicated CC numbers resolve to
  // the first field listed.
  always_comb begin
    params_next  = params_reg;
    updated_next = 1'b0;
    if (cc_hit) begin
      updated_next = 1'b1;
      if      (msg_data1 == CC_VOLUME)     params_next.volume          = sat_percent(msg_data2);
      else if (msg_data1 == CC_DETUNE)     params_next.unison_detune   = msg_data2;
      else if (msg_data1 == CC_ATTACK)     params_next.attack_time     = msg_data2;
      else if (msg_data1 == CC_DECAY)      params_next.decay_time      = msg_data2;
      else if (msg_data1 == CC_SUSTAIN)    params_next.sustain_level   = sat_percent(msg_data2);
      else if (msg_data1 == CC_RELEASE)    params_next.release_time    = msg_data2;
      else if (msg_data1 == CC_TEMPO)      params_next.tempo           = msg_data2;
      else if (msg_data1 == CC_WAVE)       params_next.wave            = map_wave(msg_data2[6:5]);
      else if (msg_data1 == CC_DUTY)       params_next.duty_cycle      = sat_percent(msg_data2);
      else if (msg_data1 == CC_DISPATCH)   params_next.dispatcher_mode = dispatcher_mode_t'(msg_data2[6]);
      else if (msg_data1 == CC_ARP_MODE)   params_next.arp_mode        = map_arp_mode(msg_data2[6:4]);
      else if (msg_data1 == CC_ARP_RATE)   params_next.arp_rate        = arp_rate_t'(msg_data2[6:4]);
      else if (msg_data1 == CC_ARP_RHYTHM) params_next.arp_rhythm      = arp_rhythm_t'(msg_data2[6:5]);
      else if (msg_data1 == CC_RESET_ALL)  params_next                 = DEFAULT_PARAMETERS;
      else                                 updated_next                = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      params_reg  <= DEFAULT_PARAMETERS;
      updated_reg <= 1'b0;
    end else begin
      params_reg  <= params_next;
      updated_reg <= updated_next;
    end
  end

  assign parameters    = params_reg;
  assign param_updated = updated_reg;

endmodule
